// File: rtl/sin_lut_qw_if.sv
// Streaming bus for the quarter-wave sine/cosine lookup: phase request in, signed amplitude out.
// The master drives requests and out_ready; the slave (the lookup) drives in_ready, out_valid and d_out.
interface sin_lut_qw_if #(
   parameter int PHASE_WIDTH = 16,
   parameter int DATA_WIDTH  = 8
);
   logic                   in_valid;
   logic                   in_ready;
   logic [PHASE_WIDTH-1:0] phase;
   logic                   cos_en;
   logic                   out_valid;
   logic                   out_ready;
   logic [DATA_WIDTH:0]    d_out;

   modport master (
      output in_valid, phase, cos_en, out_ready,
      input  in_ready, out_valid, d_out
   );

   modport slave (
      input  in_valid, phase, cos_en, out_ready,
      output in_ready, out_valid, d_out
   );
endinterface

// File: rtl/sin_lut_qw.sv
// Full-wave sine/cosine from a quarter-wave magnitude ROM with quadrant folding,
// behind a two-stage stallable valid/ready pipeline (s1: ROM read, s2: sign apply).
module sin_lut_qw #(
   parameter int DATA_WIDTH  = 8,
   parameter int ADR_WIDTH   = 8,
   parameter int PHASE_WIDTH = 16,
   parameter     INIT_FILE   = "sin_table.dat"
) (
   input  logic        clk,
   input  logic        rst_n,
   sin_lut_qw_if.slave bus
);
   localparam int     DEPTH  = 1 << ADR_WIDTH;
   localparam longint M_L    = longint'(DEPTH - 1);
   localparam longint AMP    = (longint'(1) <<< DATA_WIDTH) - 1;
   localparam longint PI_Q30 = 64'sd3373259426;

   if (PHASE_WIDTH < ADR_WIDTH + 2) begin : g_bad_phase_width
      $error("sin_lut_qw: PHASE_WIDTH must be >= ADR_WIDTH+2");
   end
   if ($bits(INIT_FILE) < 8) begin : g_bad_init_file
      $error("sin_lut_qw: INIT_FILE must name the quarter-wave table");
   end

   // Table entry k = round(AMP*sin(pi/2*k/M)), the same contents INIT_FILE holds,
   // evaluated at elaboration with a Q30 Taylor series so no file is needed.
   function automatic logic [DATA_WIDTH-1:0] sin_entry(input int k);
      longint x, x2, term, acc, scaled;
      x    = (PI_Q30 * longint'(k)) / (2 * M_L);
      x2   = (x * x) >>> 30;
      term = x;
      acc  = x;
      for (int n = 1; n < 8; n++) begin
         term = -(((term * x2) >>> 30) / longint'((2 * n) * (2 * n + 1)));
         acc  = acc + term;
      end
      scaled = (AMP * acc + (longint'(1) <<< 29)) >>> 30;
      return scaled[DATA_WIDTH-1:0];
   endfunction

   logic [DATA_WIDTH-1:0] rom [DEPTH];

   for (genvar k = 0; k < DEPTH; k++) begin : g_rom
      assign rom[k] = sin_entry(k);
   end

   logic [1:0]           quad;
   logic [ADR_WIDTH-1:0] adr;
   logic [ADR_WIDTH-1:0] fold_adr;

   assign quad     = bus.phase[PHASE_WIDTH-1 -: 2] + {1'b0, bus.cos_en};
   assign adr      = bus.phase[PHASE_WIDTH-3 -: ADR_WIDTH];
   // M-i within ADR_WIDTH bits is simply the bitwise complement
   assign fold_adr = quad[0] ? ~adr : adr;

   if (PHASE_WIDTH > ADR_WIDTH + 2) begin : g_trunc
      logic unused_phase_lsb;
      assign unused_phase_lsb = ^bus.phase[PHASE_WIDTH-ADR_WIDTH-3:0];
   end

   logic                  s1_valid_q, s1_valid_d;
   logic                  neg_q, neg_d;
   logic [DATA_WIDTH-1:0] mag_q, mag_d;
   logic                  out_valid_q, out_valid_d;
   logic [DATA_WIDTH:0]   d_out_q, d_out_d;
   logic [DATA_WIDTH:0]   mag_ext;
   logic                  adv1, adv2, accept;

   assign adv2   = !out_valid_q | bus.out_ready;
   assign adv1   = !s1_valid_q | adv2;
   assign accept = bus.in_valid & adv1;

   // Data registers load only on real transfers, so an idle or X phase never reaches d_out.
   always_comb begin
      s1_valid_d  = s1_valid_q;
      neg_d       = neg_q;
      mag_d       = mag_q;
      out_valid_d = out_valid_q;
      d_out_d     = d_out_q;
      mag_ext     = {1'b0, mag_q};
      if (adv1) s1_valid_d = bus.in_valid;
      if (accept) begin
         mag_d = rom[fold_adr];
         neg_d = quad[1];
      end
      if (adv2) begin
         out_valid_d = s1_valid_q;
         if (s1_valid_q) d_out_d = neg_q ? -mag_ext : mag_ext;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_q  <= 1'b0;
         neg_q       <= 1'b0;
         mag_q       <= '0;
         out_valid_q <= 1'b0;
         d_out_q     <= '0;
      end else begin
         s1_valid_q  <= s1_valid_d;
         neg_q       <= neg_d;
         mag_q       <= mag_d;
         out_valid_q <= out_valid_d;
         d_out_q     <= d_out_d;
      end
   end

   assign bus.in_ready  = adv1;
   assign bus.out_valid = out_valid_q;
   assign bus.d_out     = d_out_q;
endmodule

// File: tb/tb_sin_lut_qw.sv
// Bench for sin_lut_qw: directed quadrant/fold/stall/reset scenarios plus a randomized
// valid/ready stream scored against a floating-point sine model of the folding rules.
module tb_sin_lut_qw;
   localparam int  PW = 16;
   localparam int  DW = 8;
   localparam int  AW = 8;
   localparam real PI = 3.14159265358979323846;

   logic clk;
   logic rst_n;
   int   vectors;
   int   miscompares;

   sin_lut_qw_if #(.PHASE_WIDTH(PW), .DATA_WIDTH(DW)) bus ();

   sin_lut_qw #(
      .DATA_WIDTH (DW),
      .ADR_WIDTH  (AW),
      .PHASE_WIDTH(PW),
      .INIT_FILE  ("sin_table.dat")
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Quadrant/index arithmetic straight from the folding rules, magnitude from $sin.
   function automatic int model(input logic [15:0] ph, input logic c);
      int  quad, i, idx, mag;
      real m;
      quad = (int'(ph[15:14]) + int'(c)) % 4;
      i    = int'(ph[13:6]);
      idx  = (quad % 2 == 1) ? 255 - i : i;
      m    = 255.0 * $sin(PI / 2.0 * real'(idx) / 255.0);
      mag  = $rtoi(m + 0.5);
      return (quad >= 2) ? -mag : mag;
   endfunction

   function automatic int sval(input logic [DW:0] v);
      return int'($signed(v));
   endfunction

   task automatic drive(input logic v, input logic [15:0] ph, input logic c, input logic r);
      @(posedge clk);
      #1;
      bus.in_valid  = v;
      bus.phase     = ph;
      bus.cos_en    = c;
      bus.out_ready = r;
      @(negedge clk);
   endtask

   task automatic test_reset;
      bus.in_valid  = 1'b0;
      bus.phase     = '0;
      bus.cos_en    = 1'b0;
      bus.out_ready = 1'b1;
      rst_n = 1'b1;
      #1 rst_n = 1'b0;
      #2;
      vectors++;
      if (bus.out_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_out_valid: got %b want 0", bus.out_valid);
      end
      vectors++;
      if (bus.d_out !== '0) begin
         miscompares++;
         $display("FAIL reset_d_out: got %h want 000", bus.d_out);
      end
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      vectors++;
      if (bus.in_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL reset_in_ready: got %b want 1", bus.in_ready);
      end
   endtask

   task automatic test_quadrants;
      logic [15:0] ph [4];
      int          exp_v [4];
      ph    = '{16'h0000, 16'h4000, 16'h8000, 16'hC000};
      exp_v = '{0, 255, 0, -255};
      for (int n = 0; n < 6; n++) begin
         if (n < 4) drive(1'b1, ph[n], 1'b0, 1'b1);
         else       drive(1'b0, 16'h0, 1'b0, 1'b1);
         vectors++;
         if (bus.in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL quad_in_ready[%0d]: got %b want 1", n, bus.in_ready);
         end
         vectors++;
         if (bus.out_valid !== (n >= 2)) begin
            miscompares++;
            $display("FAIL quad_out_valid[%0d]: got %b want %0d", n, bus.out_valid, n >= 2);
         end
         if (n >= 2) begin
            vectors++;
            if ($isunknown(bus.d_out) || sval(bus.d_out) != exp_v[n-2]) begin
               miscompares++;
               $display("FAIL quad_d_out[%0d]: got %0d want %0d", n - 2, sval(bus.d_out), exp_v[n-2]);
            end
         end
      end
   endtask

   task automatic test_fold_cos;
      logic [15:0] ph [6];
      logic        cs [6];
      int          exp_v [6];
      ph    = '{16'h0000, 16'h4000, 16'h2000, 16'hA000, 16'h6000, 16'hE000};
      cs    = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
      exp_v = '{255, 0, 181, -181, 180, -180};
      for (int n = 0; n < 8; n++) begin
         if (n < 6) drive(1'b1, ph[n], cs[n], 1'b1);
         else       drive(1'b0, 16'h0, 1'b0, 1'b1);
         if (n >= 2) begin
            vectors++;
            if (bus.out_valid !== 1'b1 || $isunknown(bus.d_out) || sval(bus.d_out) != exp_v[n-2]) begin
               miscompares++;
               $display("FAIL fold_d_out[%0d]: got v=%b %0d want v=1 %0d",
                        n - 2, bus.out_valid, sval(bus.d_out), exp_v[n-2]);
            end
         end
      end
   endtask

   task automatic test_sweep;
      int          sb [$];
      int          sent, outs, cyc, e, diff;
      logic [10:0] s;
      logic [15:0] ph;
      sent = 0;
      outs = 0;
      cyc  = 0;
      while (outs < 2048 && cyc < 2200) begin
         s  = 11'(sent);
         ph = {s[9:0], 6'($urandom)};
         drive(sent < 2048, ph, s[10], 1'b1);
         cyc++;
         if (bus.out_valid && bus.out_ready) begin
            e = (sb.size() > 0) ? sb.pop_front() : 9999;
            diff = sval(bus.d_out) - e;
            vectors++;
            if ($isunknown(bus.d_out) || diff > 1 || diff < -1) begin
               miscompares++;
               $display("FAIL sweep[%0d]: got %0d want %0d+-1", outs, sval(bus.d_out), e);
            end
            outs++;
         end
         if (bus.in_valid && bus.in_ready) begin
            sb.push_back(model(bus.phase, bus.cos_en));
            sent++;
         end
      end
      vectors++;
      if (outs != 2048) begin
         miscompares++;
         $display("FAIL sweep_timeout: got %0d outputs want 2048", outs);
      end
   endtask

   task automatic test_stall;
      logic [15:0] ph [4];
      int          exp_v [4];
      int          acc, outs;
      ph    = '{16'h4000, 16'h2000, 16'hC000, 16'h6000};
      exp_v = '{255, 181, -255, 180};
      acc   = 0;
      outs  = 0;
      for (int n = 0; n < 14; n++) begin
         if (acc < 4) drive(1'b1, ph[acc], 1'b0, n >= 5);
         else         drive(1'b0, 16'h0, 1'b0, n >= 5);
         if (n >= 2 && n <= 4) begin
            vectors++;
            if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1 || sval(bus.d_out) != exp_v[0]) begin
               miscompares++;
               $display("FAIL stall_hold[%0d]: got rdy=%b v=%b %0d want rdy=0 v=1 %0d",
                        n, bus.in_ready, bus.out_valid, sval(bus.d_out), exp_v[0]);
            end
         end
         if (n == 4) begin
            vectors++;
            if (acc != 2) begin
               miscompares++;
               $display("FAIL stall_accepts: got %0d want 2", acc);
            end
         end
         if (bus.out_valid && bus.out_ready) begin
            vectors++;
            if (outs >= 4 || sval(bus.d_out) != exp_v[outs % 4]) begin
               miscompares++;
               $display("FAIL stall_order[%0d]: got %0d want %0d", outs, sval(bus.d_out), exp_v[outs % 4]);
            end
            outs++;
         end
         if (bus.in_valid && bus.in_ready) acc++;
      end
      vectors++;
      if (outs != 4) begin
         miscompares++;
         $display("FAIL stall_count: got %0d outputs want 4", outs);
      end
   endtask

   task automatic test_reset_mid;
      drive(1'b0, 16'h0, 1'b0, 1'b1);
      drive(1'b1, 16'h4000, 1'b0, 1'b0);
      drive(1'b1, 16'hC000, 1'b0, 1'b0);
      @(posedge clk);
      #1 bus.in_valid = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      vectors++;
      if (bus.out_valid !== 1'b0 || bus.d_out !== '0) begin
         miscompares++;
         $display("FAIL midreset_clear: got v=%b d=%h want v=0 d=000", bus.out_valid, bus.d_out);
      end
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      vectors++;
      if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL midreset_release: got rdy=%b v=%b want rdy=1 v=0", bus.in_ready, bus.out_valid);
      end
      for (int n = 0; n < 5; n++) begin
         drive(n == 0, 16'h4000, 1'b0, 1'b1);
         vectors++;
         if (bus.out_valid !== (n == 2)) begin
            miscompares++;
            $display("FAIL midreset_valid[%0d]: got %b want %0d", n, bus.out_valid, n == 2);
         end
         if (n == 2) begin
            vectors++;
            if (sval(bus.d_out) != 255) begin
               miscompares++;
               $display("FAIL midreset_d_out: got %0d want 255", sval(bus.d_out));
            end
         end
      end
   endtask

   task automatic test_random;
      localparam int N = 10000;
      int          sb [$];
      int          sent, outs, cyc, e, diff;
      logic        v, r, c, hold;
      logic [15:0] ph;
      logic [DW:0] held;
      sent = 0;
      outs = 0;
      cyc  = 0;
      hold = 1'b0;
      held = '0;
      while (outs < N && cyc < 50000) begin
         v  = (sent < N) && ($urandom_range(0, 1) == 1);
         r  = ($urandom_range(0, 1) == 1);
         ph = 16'($urandom);
         c  = 1'($urandom_range(0, 1));
         drive(v, v ? ph : 16'hxxxx, v ? c : 1'bx, r);
         cyc++;
         if (hold) begin
            vectors++;
            if (bus.out_valid !== 1'b1 || bus.d_out !== held) begin
               miscompares++;
               $display("FAIL rand_stall_stable: got v=%b %h want v=1 %h", bus.out_valid, bus.d_out, held);
            end
         end
         hold = bus.out_valid && !bus.out_ready;
         held = bus.d_out;
         if (bus.out_valid && bus.out_ready) begin
            e = (sb.size() > 0) ? sb.pop_front() : 9999;
            diff = sval(bus.d_out) - e;
            vectors++;
            if ($isunknown(bus.d_out) || diff > 1 || diff < -1) begin
               miscompares++;
               $display("FAIL rand_sample[%0d]: got %0d want %0d+-1", outs, sval(bus.d_out), e);
            end
            outs++;
         end
         if (bus.in_valid && bus.in_ready) begin
            sb.push_back(model(bus.phase, bus.cos_en));
            sent++;
         end
      end
      vectors++;
      if (outs != N || sb.size() != 0) begin
         miscompares++;
         $display("FAIL rand_complete: got %0d outputs, %0d pending want %0d, 0", outs, sb.size(), N);
      end
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      test_reset();
      test_quadrants();
      test_fold_cos();
      test_sweep();
      test_stall();
      test_reset_mid();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
